// File: rtl/deser_flex_pkg.sv
// Shared types and helpers for the flexible serial-to-parallel converter.
package deser_flex_pkg;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Accumulator position for the bit arriving when cnt bits are already stored.
  function automatic int unsigned bit_index(input int unsigned cnt,
                                            input int unsigned data_w,
                                            input bit          msb_first);
    return msb_first ? (data_w - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/deser_out_slot.sv
// One-entry valid/ready output register holding a finished word and its bit count.
module deser_out_slot #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_val,
  output logic              o_slot_free_c
);

  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;
  logic              r_val;

  // A word popped this cycle frees the slot for a same-cycle reload.
  assign o_slot_free_c = !r_val || i_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_data <= '0;
      r_len  <= '0;
      r_val  <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_len  <= i_len;
      r_val  <= 1'b1;
    end else if (i_ready) begin
      r_val  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_len  = r_len;
  assign o_val  = r_val;

endmodule

// File: rtl/deser_flex.sv
// Parametrised deserializer: packs accepted serial bits into DATA_W words, supports flush and output backpressure.
module deser_flex
  import deser_flex_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned LEN_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_len_o,
  output logic              deser_data_val_o,
  input  logic              deser_ready_i
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  state_e            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_ready;

  logic              w_accept;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_acc_new;
  logic [LEN_W-1:0]  w_cnt_eff;
  logic              w_close;
  logic              w_slot_free;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic [LEN_W-1:0]  w_load_len;

  // Word/count as they stand including a bit accepted this cycle, and the close decision.
  always_comb begin
    w_accept    = data_val_i && r_ready;
    w_idx       = IDX_W'(bit_index(32'(r_cnt), DATA_W, MSB_FIRST));
    w_acc_new   = r_acc;
    if (w_accept) begin
      w_acc_new[w_idx] = data_i;
    end
    w_cnt_eff   = r_cnt + LEN_W'(w_accept);
    w_close     = (r_state == ST_ACC) &&
                  ((w_accept && (w_cnt_eff == LEN_W'(DATA_W))) ||
                   (flush_i && (w_cnt_eff != '0)));
    w_load      = w_slot_free && (w_close || (r_state == ST_HOLD));
    w_load_data = (r_state == ST_HOLD) ? r_acc : w_acc_new;
    w_load_len  = (r_state == ST_HOLD) ? r_cnt : w_cnt_eff;
  end

  // Collect bits; park a closed word in the accumulator while the output slot is busy.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          r_ready <= 1'b1;
          if (w_close) begin
            if (w_slot_free) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc   <= w_acc_new;
              r_cnt   <= w_cnt_eff;
              r_state <= ST_HOLD;
              r_ready <= 1'b0;
            end
          end else if (w_accept) begin
            r_acc <= w_acc_new;
            r_cnt <= w_cnt_eff;
          end
        end
        ST_HOLD: begin
          if (w_slot_free) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_ACC;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ACC;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready_o = r_ready;

  deser_out_slot #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_out_slot (
    .i_clk         (clk_i),
    .i_arst_n      (arst_n_i),
    .i_load        (w_load),
    .i_data        (w_load_data),
    .i_len         (w_load_len),
    .i_ready       (deser_ready_i),
    .o_data        (deser_data_o),
    .o_len         (deser_len_o),
    .o_val         (deser_data_val_o),
    .o_slot_free_c (w_slot_free)
  );

endmodule

// File: tb/tb_deser_flex.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a bit-list model predicts words.
module tb_deser_flex;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = $clog2(DW + 1);

  logic clk = 1'b0;
  logic arst_n_i = 1'b1;
  logic data_i = 1'b0;
  logic data_val_i = 1'b0;
  logic flush_i = 1'b0;
  logic deser_ready_i = 1'b0;

  logic          rdy  [2];
  logic [DW-1:0] dout [2];
  logic [LW-1:0] dlen [2];
  logic          dval [2];

  always #5 clk = ~clk;

  deser_flex #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
    .clk_i            (clk),
    .arst_n_i         (arst_n_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .data_ready_o     (rdy[0]),
    .flush_i          (flush_i),
    .deser_data_o     (dout[0]),
    .deser_len_o      (dlen[0]),
    .deser_data_val_o (dval[0]),
    .deser_ready_i    (deser_ready_i)
  );

  deser_flex #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i            (clk),
    .arst_n_i         (arst_n_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .data_ready_o     (rdy[1]),
    .flush_i          (flush_i),
    .deser_data_o     (dout[1]),
    .deser_len_o      (dlen[1]),
    .deser_data_val_o (dval[1]),
    .deser_ready_i    (deser_ready_i)
  );

  typedef struct packed {
    logic [DW-1:0] msb;
    logic [DW-1:0] lsb;
    logic [LW-1:0] len;
  } exp_t;

  exp_t exp_q[$];
  bit   cur[$];
  int   outstanding = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build both bit orders of the closed word from the list of bits received.
  function automatic void close_word();
    exp_t e;
    e = '0;
    e.len = LW'(cur.size());
    for (int i = 0; i < cur.size(); i++) begin
      if (cur[i]) begin
        e.msb = e.msb | (DW'(1) << (DW - 1 - i));
        e.lsb = e.lsb | (DW'(1) << i);
      end
    end
    exp_q.push_back(e);
    cur.delete();
    outstanding++;
  endfunction

  // One clock of the reference model; the block buffers at most two finished words.
  task automatic step(output bit acc);
    bit pred_rdy;
    bit fl;
    @(negedge clk);
    pred_rdy = (outstanding < 2);
    chk("data_ready_o msb", 32'(rdy[0]), 32'(pred_rdy));
    chk("data_ready_o lsb", 32'(rdy[1]), 32'(pred_rdy));
    chk("deser_data_val_o msb", 32'(dval[0]), 32'(outstanding > 0));
    chk("deser_data_val_o lsb", 32'(dval[1]), 32'(outstanding > 0));
    acc = data_val_i && pred_rdy;
    fl  = flush_i && pred_rdy;
    if (outstanding > 0 && deser_ready_i) outstanding--;
    if (acc) cur.push_back(data_i);
    if ((acc && cur.size() == int'(DW)) || (fl && cur.size() > 0)) close_word();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit f);
    bit acc;
    acc = 1'b0;
    data_i = b;
    data_val_i = 1'b1;
    flush_i = f;
    for (int k = 0; k < 40; k++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) chk("accept timeout", 32'(0), 32'(1));
    data_val_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    data_val_i = 1'b0;
    flush_i = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic flush_only();
    bit acc;
    flush_i = 1'b1;
    step(acc);
    flush_i = 1'b0;
  endtask

  task automatic do_reset();
    data_val_i = 1'b0;
    flush_i = 1'b0;
    #3 arst_n_i = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset data_ready_o", 32'(rdy[k]), 32'(0));
      chk("reset deser_data_val_o", 32'(dval[k]), 32'(0));
      chk("reset deser_data_o", 32'(dout[k]), 32'(0));
      chk("reset deser_len_o", 32'(dlen[k]), 32'(0));
    end
    exp_q.delete();
    cur.delete();
    outstanding = 0;
    @(negedge clk);
    @(negedge clk);
    #2 arst_n_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset data_ready_o msb", 32'(rdy[0]), 32'(1));
    chk("post-reset data_ready_o lsb", 32'(rdy[1]), 32'(1));
  endtask

  // Monitor: pop expected word on each handshake; outputs must hold while stalled.
  exp_t          m_e;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] pv_msb, pv_lsb;
  logic [LW-1:0] pv_len;

  always @(negedge clk) begin
    if (!arst_n_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall hold val", 32'(dval[0]), 32'(1));
        chk("stall hold data msb", 32'(dout[0]), 32'(pv_msb));
        chk("stall hold data lsb", 32'(dout[1]), 32'(pv_lsb));
        chk("stall hold len", 32'(dlen[0]), 32'(pv_len));
      end
      if (dval[0] && deser_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected word", 32'(1), 32'(0));
        end else begin
          m_e = exp_q.pop_front();
          chk("word msb", 32'(dout[0]), 32'(m_e.msb));
          chk("word lsb", 32'(dout[1]), 32'(m_e.lsb));
          chk("len msb", 32'(dlen[0]), 32'(m_e.len));
          chk("len lsb", 32'(dlen[1]), 32'(m_e.len));
        end
      end
      stall_prev = dval[0] && !deser_ready_i;
      pv_msb = dout[0];
      pv_lsb = dout[1];
      pv_len = dlen[0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit hold_bit;
    hold_bit = 1'b0;
    do_reset();

    // Alternating 1,0 pattern, one full word, then 32 contiguous bits.
    deser_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(bit'(i % 2 == 0), 1'b0);
    idle(2);
    for (int i = 0; i < 32; i++) send_bit(bit'(i % 3 == 0), 1'b0);
    idle(2);

    // Partial word 1,1,0,1,1 flushed; empty flush; flush on the third bit.
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    flush_only();
    idle(2);
    flush_only();
    idle(2);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    idle(2);

    // Consumer stalled across two full words, then released.
    deser_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) send_bit(bit'((i / 2) % 2), 1'b0);
    idle(3);
    flush_only();
    deser_ready_i = 1'b1;
    idle(4);

    // Reset mid-word and mid-hold discards data.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    do_reset();
    deser_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b0);
    do_reset();
    deser_ready_i = 1'b1;
    idle(3);

    // Randomised traffic with varying backpressure; upstream holds unaccepted bits.
    for (int c = 0; c < 1200; c++) begin
      case ((c / 200) % 3)
        0:       deser_ready_i = ($urandom_range(0, 3) != 0);
        1:       deser_ready_i = ($urandom_range(0, 3) == 0);
        default: deser_ready_i = 1'b1;
      endcase
      if (!hold_bit) begin
        data_val_i = ($urandom_range(0, 3) != 0);
        data_i     = 1'($urandom());
      end
      flush_i = ($urandom_range(0, 11) == 0);
      step(acc);
      hold_bit = data_val_i && !acc;
    end

    deser_ready_i = 1'b1;
    for (int k = 0; k < 10 && outstanding > 0; k++) idle(1);
    idle(2);
    chk("scoreboard drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
